// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative DIV/DIVU unit.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    // Step counter must be able to hold WIDTH-1 without wrapping.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

    localparam int unsigned DIV_CNT_W = cnt_width(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
module div_step #(
    parameter int unsigned WIDTH = div_pkg::DIV_WIDTH
) (
    // Only the low WIDTH-1 bits of the partial remainder are needed: the MSB
    // is shifted out and is always zero at that point because rem < 2**step.
    input  logic [WIDTH-2:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH-1:0] rem_next,
    output logic             qbit
);

    logic [WIDTH-1:0] rem_shift;
    logic [WIDTH:0]   trial;

    // Shift in the next dividend bit and try to subtract the divisor.
    always_comb begin
        rem_shift = {rem, dvd_msb};
        trial     = {1'b0, rem_shift} - {1'b0, dsr};
        qbit      = ~trial[WIDTH];
        rem_next  = qbit ? trial[WIDTH-1:0] : rem_shift;
    end

endmodule

// File: rtl/div_unit.sv
// Iterative multi-cycle divider for DIV/DIVU: quotient to LO, remainder to HI.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    localparam int unsigned CW = cnt_width(WIDTH);

    div_state_t       state, state_next;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem[WIDTH-2:0]),
        .dvd_msb  (dvd[WIDTH-1]),
        .dsr      (dsr),
        .rem_next (step_rem),
        .qbit     (step_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = CALC;
            end
            CALC: if (cnt == CW'(WIDTH - 1)) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, restoring iterations and sign fixup of the results.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd   <= '0;
            dsr   <= '0;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            q     <= '0;
            r     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_r <= is_signed & dividend[WIDTH-1];
                    dvd   <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
                    dsr   <= (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
                    rem   <= '0;
                    cnt   <= '0;
                end
                CALC: begin
                    rem <= step_rem;
                    dvd <= {dvd[WIDTH-2:0], step_q};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    // With a zero divisor every step subtracts nothing, so rem
                    // ends up equal to the working dividend; re-applying the
                    // dividend sign restores the original operand exactly.
                    if (dsr == '0) q <= '1;
                    else           q <= neg_q ? -dvd : dvd;
                    r <= neg_r ? -rem : rem;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Iterative multi-cycle divider for the DIV/DIVU instructions of the 54-instruction MIPS core.
- Accepts operands from the register-file read stage.
- Produces a quotient (to LO) and a remainder (to HI). These feed the 32-bit 4:1 result-select mux in front of the HI/LO registers and the writeback path.
- Uses a start/busy/done handshake so the control unit can stall the pipeline while a division is in progress.

Parameters:
WIDTH, 32, operand and result width in bits. The iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  synchronous, active-high reset
start  input  1  request a division; sampled only in IDLE
is_signed  input  1  1 = DIV (two's complement), 0 = DIVU
dividend  input  WIDTH  rs operand; sampled with start
divisor  input  WIDTH  rt operand; sampled with start
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse when q/r are valid
q  output  WIDTH  quotient (to LO); registered
r  output  WIDTH  remainder (to HI); registered

Behaviour:
- Reset: already decided — one clock (clk); reset rst is synchronous and active-high. On rst = 1 at a rising edge:
  - state = IDLE.
  - busy = 0, done = 0, q = 0, r = 0.
  - All internal working registers cleared.
  - rst has priority over every other input. Reset mid-division aborts the operation with no done pulse.
- States: IDLE, CALC, FIX, DONE. The encoding is a 2-bit constant.
- IDLE:
  - If start = 1 at edge E0: latch is_signed and the operand signs; load the working dividend and divisor; clear the partial remainder and step counter; go to CALC.
  - Working operands are absolute values when is_signed = 1, raw values otherwise.
  - If start = 0: stay in IDLE.
- CALC: one restoring step per edge.
  - rem_shift = {rem[WIDTH-2:0], dvd[WIDTH-1]}; compute trial = rem_shift - dsr at WIDTH+1 bits.
  - If trial is non-negative: rem = trial and the quotient bit = 1. Otherwise rem = rem_shift and the quotient bit = 0.
  - dvd shifts left with the quotient bit inserted at the LSB.
  - The counter increments. After WIDTH steps (edges E1..E32) go to FIX.
- FIX (edge E33):
  - Quotient is negated iff is_signed = 1 and the operand signs differ.
  - Remainder is negated iff is_signed = 1 and the dividend is negative.
  - q and r are written; go to DONE.
- DONE: done = 1 for exactly this one cycle, then return to IDLE.
- busy = 1 in CALC, FIX and DONE; 0 in IDLE. busy rises in the cycle after E0.
- Latency: done is high in the cycle following E33. The next start is accepted in the cycle after done, so there are 35 cycles between back-to-back starts.
- start while busy: ignored. Operands are not re-sampled.
- q and r hold their values until the next FIX or rst. They never change during CALC.
- Divide by zero (divisor = 0): completes with normal latency. Forced result q = all ones, r = original dividend, for both signed and unsigned. No sign fixup is applied.
- Signed overflow (0x80000000 / 0xFFFFFFFF): q = 0x80000000, r = 0. This falls out of the absolute-value path with no special case.
- Absolute value of 0x80000000 is 0x80000000 read as unsigned.

Decomposition:
- Package div_pkg holds:
  - the state encoding constants (IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3);
  - the default WIDTH;
  - the counter width (clog2(WIDTH) + 1).
- One natural sub-module, div_step: a combinational single restoring iteration.
  - Inputs: rem, dvd MSB, dsr.
  - Outputs: next rem, quotient bit.
  - It is instantiated once inside div_unit.
- Sequencing, sign handling and output registers stay in div_unit.

Test Plan:
- DIVU 100 / 7 → q = 14 (0x0000000E), r = 2. done is high exactly in the cycle after the 33rd edge following the start edge. busy is high from E0+1 through the done cycle.
- DIV -100 (0xFFFFFF9C) / 7 → q = 0xFFFFFFF2 (-14), r = 0xFFFFFFFE (-2). Also DIV 100 / -7 → q = 0xFFFFFFF2, r = 2.
- DIV 0x80000000 / 0xFFFFFFFF → q = 0x80000000, r = 0. Also DIVU 0xFFFFFFFF / 1 → q = 0xFFFFFFFF, r = 0.
- DIVU and DIV 0x12345678 / 0 → q = 0xFFFFFFFF, r = 0x12345678, with normal latency.
- Start 100 / 7, pulse start again at cycle 5 with 9 / 3 → the second request is ignored: a single done, q = 14, r = 2. Start 9 / 3 after done → q = 3, r = 0.
- Start 100 / 7, assert rst at cycle 10 → the next cycle shows busy = 0, done = 0, q = 0, r = 0, and no done pulse follows. A new start then completes normally.
